// File: rtl/msp430_pkg.sv
// ---------------------------------------------------------------------------
// msp430_pkg
// Shared definitions for the msp430 wakeup logic.
//   wkup_state_e    : wakeup FSM states (2-bit binary encoding)
//   *_MIN / *_MAX   : legal parameter ranges for the wakeup block
//   id_width()      : width of a source index, never less than one bit
// ---------------------------------------------------------------------------
package msp430_pkg;

   typedef enum logic [1:0] {
      WK_IDLE = 2'd0,
      WK_REQ  = 2'd1,
      WK_HOLD = 2'd2
   } wkup_state_e;

   localparam int unsigned NSRC_MIN        = 1;
   localparam int unsigned NSRC_MAX        = 8;
   localparam int unsigned SYNC_STAGES_MIN = 2;
   localparam int unsigned SYNC_STAGES_MAX = 3;
   localparam int unsigned HOLD_CYC_MIN    = 1;
   localparam int unsigned HOLD_CYC_MAX    = 15;

   // Index width for n sources; a single source still gets a 1-bit id.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/msp430_sync_cell.sv
// ---------------------------------------------------------------------------
// msp430_sync_cell
// Single-bit synchronizer: SYNC_STAGES flops in series.
//   mclk     : destination clock
//   reset_n  : synchronous active-low reset, clears every stage
//   data_in  : asynchronous input bit
//   data_out : synchronized bit, SYNC_STAGES mclk edges after data_in
// ---------------------------------------------------------------------------
module msp430_sync_cell #(
   parameter int SYNC_STAGES = 2
) (
   input  logic mclk,
   input  logic reset_n,
   input  logic data_in,
   output logic data_out
);

   logic [SYNC_STAGES-1:0] chain_q;
   logic [SYNC_STAGES-1:0] chain_d;

   always_comb begin
      chain_d = {chain_q[SYNC_STAGES-2:0], data_in};
   end

   always_ff @(posedge mclk) begin
      if (!reset_n) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign data_out = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/msp430_wakeup_sync.sv
// ---------------------------------------------------------------------------
// msp430_wakeup_sync
// Synchronizes asynchronous wakeup lines, captures their rising edges as
// pending flags and raises a wakeup request to the clock module while the
// CPU is off, serving the lowest pending source first.
//   mclk      : system clock
//   reset_n   : synchronous active-low reset
//   wkup_in   : asynchronous gated wakeup lines, one per source
//   cpuoff    : CPU low-power flag (mclk domain)
//   wkup_ack  : single-cycle acknowledge of the current request
//   wkup_req  : registered request, high only in the REQ state
//   wkup_id   : index of the source being served (valid with wkup_req)
//   wkup_pend : registered pending flags, one per source
// ---------------------------------------------------------------------------
module msp430_wakeup_sync
   import msp430_pkg::*;
#(
   parameter  int NSRC        = 4,
   parameter  int SYNC_STAGES = 2,
   parameter  int HOLD_CYC    = 3,
   localparam int IDW         = id_width(NSRC)
) (
   input  logic            mclk,
   input  logic            reset_n,
   input  logic [NSRC-1:0] wkup_in,
   input  logic            cpuoff,
   input  logic            wkup_ack,
   output logic            wkup_req,
   output logic [IDW-1:0]  wkup_id,
   output logic [NSRC-1:0] wkup_pend
);

   // Priming counter runs until the history flops hold the first real
   // post-reset sample; width covers the terminal value SYNC_STAGES+1.
   localparam int                 PRIME_W    = $clog2(SYNC_STAGES + 2);
   localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);
   localparam logic [3:0]         HOLD_LOAD  = 4'(HOLD_CYC - 1);

   logic [NSRC-1:0]    sync_out;
   logic [NSRC-1:0]    hist_q,  hist_d;
   logic [NSRC-1:0]    pend_q,  pend_d;
   logic [NSRC-1:0]    edge_vec;
   logic [NSRC-1:0]    clr_mask;
   logic [PRIME_W-1:0] prime_q, prime_d;
   logic               primed;
   wkup_state_e        state_q, state_d;
   logic [IDW-1:0]     id_q,    id_d;
   logic [IDW-1:0]     low_idx;
   logic [3:0]         cnt_q,   cnt_d;
   logic               req_q,   req_d;

   // ------------------------------------------------------------------
   // Per-source synchronizers
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NSRC; gi++) begin : g_sync
         msp430_sync_cell #(
            .SYNC_STAGES (SYNC_STAGES)
         ) u_sync (
            .mclk     (mclk),
            .reset_n  (reset_n),
            .data_in  (wkup_in[gi]),
            .data_out (sync_out[gi])
         );
      end
   endgenerate

   // ------------------------------------------------------------------
   // Edge detection. Until the chain has refilled after reset, the history
   // simply follows the synchronizer output and no edges are reported, so
   // a line already high at reset release is seen as a level.
   // ------------------------------------------------------------------
   always_comb begin
      primed   = (prime_q == PRIME_DONE);
      prime_d  = primed ? prime_q : prime_q + 1'b1;
      hist_d   = sync_out;
      edge_vec = primed ? (sync_out & ~hist_q) : '0;
   end

   // Lowest set pending index; highest index scanned first so the
   // lowest one wins.
   always_comb begin
      low_idx = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            low_idx = IDW'(i);
         end
      end
   end

   // ------------------------------------------------------------------
   // FSM next state, served id, hold counter and pend clear
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      cnt_d    = cnt_q;
      clr_mask = '0;
      unique case (state_q)
         WK_IDLE: begin
            if (cpuoff && (|pend_q)) begin
               state_d = WK_REQ;
               id_d    = low_idx;
            end
         end
         WK_REQ: begin
            // Acknowledge has priority over the CPU waking by other means.
            if (wkup_ack) begin
               state_d  = WK_HOLD;
               cnt_d    = HOLD_LOAD;
               clr_mask = NSRC'(1) << id_q;
            end else if (!cpuoff) begin
               state_d = WK_IDLE;
            end
         end
         WK_HOLD: begin
            if (cnt_q == 4'd0) begin
               state_d = WK_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = WK_IDLE;
         end
      endcase
   end

   // A new edge on the bit being cleared wins over the clear.
   always_comb begin
      pend_d = (pend_q & ~clr_mask) | edge_vec;
      req_d  = (state_d == WK_REQ);
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge mclk) begin
      if (!reset_n) begin
         hist_q  <= '0;
         prime_q <= '0;
         pend_q  <= '0;
         state_q <= WK_IDLE;
         id_q    <= '0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         prime_q <= prime_d;
         pend_q  <= pend_d;
         state_q <= state_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
      end
   end

   assign wkup_req  = req_q;
   assign wkup_id   = id_q;
   assign wkup_pend = pend_q;

endmodule

// File: tb/tb_msp430_wakeup_sync.sv
// ---------------------------------------------------------------------------
// tb_msp430_wakeup_sync
// Scoreboard bench: a behavioural model updated on every mclk edge pushes
// the expected outputs into a queue; an independent monitor pops one entry
// per edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_msp430_wakeup_sync;

   localparam int N = 4;
   localparam int S = 2;
   localparam int H = 3;

   typedef struct {
      logic       req;
      logic [1:0] id;
      logic [3:0] pend;
   } exp_t;

   logic         clk;
   logic         reset_n;
   logic [N-1:0] wkup_in;
   logic         cpuoff;
   logic         wkup_ack;
   logic         wkup_req;
   logic [1:0]   wkup_id;
   logic [N-1:0] wkup_pend;

   int n_checks = 0;
   int n_fails  = 0;

   exp_t exp_q[$];

   // Model state: 0 = idle, 1 = requesting, 2 = holding off
   int         m_state = 0;
   logic [1:0] m_id    = '0;
   logic [3:0] m_pend  = '0;
   int         m_rem   = 0;
   int         m_n     = 0;
   logic [3:0] m_prev  = '0;
   logic [3:0] m_ev_q[$];

   msp430_wakeup_sync #(
      .NSRC        (N),
      .SYNC_STAGES (S),
      .HOLD_CYC    (H)
   ) dut (
      .mclk      (clk),
      .reset_n   (reset_n),
      .wkup_in   (wkup_in),
      .cpuoff    (cpuoff),
      .wkup_ack  (wkup_ack),
      .wkup_req  (wkup_req),
      .wkup_id   (wkup_id),
      .wkup_pend (wkup_pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] lowest(input logic [3:0] p);
      for (int i = 0; i < 4; i++) begin
         if (p[i]) return 2'(i);
      end
      return 2'd0;
   endfunction

   // One model step per mclk edge, using the inputs sampled on that edge.
   // A rising edge is a 0->1 change between consecutive post-reset samples
   // (the first sample counts as a level) and reaches pend S edges later.
   task automatic model_step();
      logic [3:0] ev;
      logic [3:0] app;
      logic [3:0] clr;
      if (!reset_n) begin
         m_state = 0;
         m_id    = '0;
         m_pend  = '0;
         m_rem   = 0;
         m_n     = 0;
         m_prev  = '0;
         m_ev_q.delete();
      end else begin
         m_n++;
         ev     = (m_n >= 2) ? (wkup_in & ~m_prev) : 4'b0000;
         m_prev = wkup_in;
         m_ev_q.push_back(ev);
         app = 4'b0000;
         if (m_ev_q.size() > S) app = m_ev_q.pop_front();
         clr = 4'b0000;
         case (m_state)
            0: begin
               if (cpuoff && (m_pend != 4'b0000)) begin
                  m_state = 1;
                  m_id    = lowest(m_pend);
               end
            end
            1: begin
               if (wkup_ack) begin
                  clr[m_id] = 1'b1;
                  m_state   = 2;
                  m_rem     = H;
                  $display("t=%0t served source %0d pend_before=%b", $time, m_id, m_pend);
               end else if (!cpuoff) begin
                  m_state = 0;
               end
            end
            default: begin
               m_rem--;
               if (m_rem == 0) m_state = 0;
            end
         endcase
         m_pend = (m_pend & ~clr) | app;
      end
      exp_q.push_back('{req: (m_state == 1), id: m_id, pend: m_pend});
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Monitor: compares every edge's DUT outputs against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL scoreboard_empty t=%0t: no expected entry", $time);
         end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (wkup_req !== e.req) begin
               n_fails++;
               $display("FAIL wkup_req t=%0t: got %b, expected %b", $time, wkup_req, e.req);
            end
            n_checks++;
            if (wkup_id !== e.id) begin
               n_fails++;
               $display("FAIL wkup_id t=%0t: got %0d, expected %0d", $time, wkup_id, e.id);
            end
            n_checks++;
            if (wkup_pend !== e.pend) begin
               n_fails++;
               $display("FAIL wkup_pend t=%0t: got %b, expected %b", $time, wkup_pend, e.pend);
            end
         end
      end
   end

   // Waits (bounded) until the model says a request is outstanding.
   task automatic wait_req(input int maxc);
      int k;
      k = 0;
      while (m_state != 1 && k < maxc) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (m_state != 1) begin
         n_fails++;
         $display("FAIL wait_req t=%0t: no request within %0d cycles, required one", $time, maxc);
      end
   endtask

   task automatic do_ack();
      wkup_ack = 1'b1;
      @(negedge clk);
      wkup_ack = 1'b0;
   endtask

   initial begin
      int idx;
      reset_n  = 1'b0;
      wkup_in  = '0;
      cpuoff   = 1'b1;
      wkup_ack = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Single source, held high: one pend, one request with id 0
      repeat (6) @(negedge clk);
      wkup_in = 4'b0001;
      wait_req(10);
      do_ack();
      repeat (5) @(negedge clk);

      // Sources 1 and 2 together: 1 served first, then 2 after HOLD
      wkup_in = 4'b0000;
      repeat (4) @(negedge clk);
      wkup_in = 4'b0110;
      wait_req(10);
      do_ack();
      wait_req(15);
      do_ack();
      repeat (3) @(negedge clk);

      // CPU wakes by other means while requesting
      wkup_in = 4'b1110;
      wait_req(10);
      cpuoff = 1'b0;
      repeat (2) @(negedge clk);
      cpuoff = 1'b1;
      wait_req(5);
      do_ack();
      repeat (5) @(negedge clk);

      // New edge on source 0 lands on the same edge as its acknowledge
      wkup_in = 4'b0000;
      repeat (3) @(negedge clk);
      wkup_in = 4'b0001;
      wait_req(10);
      wkup_in = 4'b0000;
      repeat (3) @(negedge clk);
      wkup_in = 4'b0001;
      repeat (S) @(negedge clk);
      do_ack();
      wait_req(15);
      do_ack();
      repeat (5) @(negedge clk);

      // Reset during HOLD (counter at HOLD_CYC-1), then lines high across release
      wkup_in = 4'b0000;
      repeat (3) @(negedge clk);
      wkup_in = 4'b1000;
      wait_req(10);
      do_ack();
      reset_n = 1'b0;
      @(negedge clk);
      wkup_in = 4'b1111;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (25) @(negedge clk);

      // Randomized traffic, including stray acks and occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            idx = int'($urandom_range(0, N - 1));
            wkup_in[idx] = ~wkup_in[idx];
         end
         cpuoff   = ($urandom_range(0, 7) != 0);
         wkup_ack = (m_state == 1) ? ($urandom_range(0, 2) == 0)
                                   : ($urandom_range(0, 9) == 0);
         reset_n  = ($urandom_range(0, 299) != 0);
         @(negedge clk);
      end
      wkup_ack = 1'b0;
      reset_n  = 1'b1;
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/msp430_wakeup_sync.md
MSP430_WAKEUP_SYNC -- requirements
Module: msp430_wakeup_sync

Interface
REQ-001 Parameter NSRC, default 4: number of wakeup sources, legal range 1..8.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth, legal range 2..3.
REQ-003 Parameter HOLD_CYC, default 3: minimum mclk cycles in HOLD after acknowledge, legal range 1..15.
REQ-004 Clock and reset: one clock; reset is synchronous and active-low.
REQ-005 mclk  input  1  system clock; all state updates on rising edge.
REQ-006 reset_n  input  1  synchronous active-low reset.
REQ-007 wkup_in  input  NSRC  asynchronous, glitch-free gated wakeup lines (outputs of the wakeup AND gates).
REQ-008 cpuoff  input  1  CPU low-power flag, synchronous to mclk.
REQ-009 wkup_ack  input  1  CPU/clock-module acknowledge, synchronous, single-cycle pulse.
REQ-010 wkup_req  output  1  registered wakeup request to the clock module.
REQ-011 wkup_id  output  clog2(NSRC), minimum 1 bit  index of the source being served; valid while wkup_req=1.
REQ-012 wkup_pend  output  NSRC  registered pending flags, one per source.

Function
REQ-013 Each wkup_in bit SHALL pass through a SYNC_STAGES flop chain followed by one history flop; edge = sync_out & ~history.
REQ-014 A rising edge SHALL set wkup_pend[i] on the next edge: wkup_in rising before mclk edge k gives wkup_pend[i]=1 after edge k+SYNC_STAGES.
REQ-015 Levels and falling edges SHALL NOT set pend; a source held high SHALL produce exactly one pend.
REQ-016 FSM states: IDLE, REQ, HOLD; encoding is 2-bit binary; the FSM is Moore, wkup_req=1 only in REQ.
REQ-017 IDLE->REQ when cpuoff=1 and any wkup_pend=1; wkup_id latches the lowest set index on the same edge.
REQ-018 REQ->HOLD on wkup_ack=1: clear wkup_pend[wkup_id]; load the hold counter with HOLD_CYC-1.
REQ-019 REQ->IDLE when cpuoff=0 and wkup_ack=0 (CPU woke by other means); pend is not cleared.
REQ-020 HOLD: the counter decrements each cycle; HOLD->IDLE when the counter is 0; total HOLD residency is HOLD_CYC cycles.
REQ-021 wkup_ack outside REQ SHALL be ignored.
REQ-022 On a simultaneous set and clear of the same pend bit, set wins; the bit stays 1.
REQ-023 wkup_id SHALL remain stable throughout REQ, even if a lower-index pend sets meanwhile.
REQ-024 Earliest wkup_req: after edge k+SYNC_STAGES+1 for an edge before k, with cpuoff=1 and the FSM in IDLE.

Reset
REQ-025 When reset_n=0 at a mclk edge, the following SHALL be cleared on that edge regardless of state: synchronizer, history, pend, counter, and wkup_id to 0; the FSM goes to IDLE.
REQ-026 After reset: wkup_req=0, wkup_pend=0, wkup_id=0.
REQ-027 A wkup_in already high at reset release SHALL NOT generate pend, because history is re-initialised through the chain and the first synchronized sample is treated as a level.

Structure
REQ-028 The FSM state enumeration and the NSRC/HOLD_CYC range limits SHALL live in the shared msp430 package.
REQ-029 The per-bit synchronizer SHALL be a sub-module, msp430_sync_cell, with parameter SYNC_STAGES and ports mclk, reset_n, data_in, data_out.
REQ-030 No latches; no combinational path from wkup_in to any output.

Verification
REQ-031 Reset, cpuoff=1: wkup_in=0001 before edge 10 -> wkup_pend=0001 after edge 12, wkup_req=1 and wkup_id=0 after edge 13.
REQ-032 Sources 2 and 1 rise together: wkup_id=1 served first; ack -> pend=0100; after 3 HOLD cycles, REQ again with wkup_id=2.
REQ-033 In REQ, drop cpuoff with no ack -> IDLE the next cycle; pend is unchanged; wkup_req=0.
REQ-034 A new edge on source 0 arrives on the same edge as ack of source 0 -> pend[0] remains 1 and a second request follows HOLD.
REQ-035 wkup_in=1111 held across reset release -> pend stays 0000 and no wkup_req for 20 cycles.
REQ-036 reset_n=0 asserted during HOLD with counter=2 -> all outputs 0 and state IDLE after the next edge.
